// File: rtl/sbox_share_feeder_if.sv
// Handshake and share bus between the datapath, the masked S-box feeder and the S-box consumer.
interface sbox_share_feeder_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_s0;
   logic [7:0] in_s1;
   logic [7:0] rnd;
   logic       rnd_valid;
   logic       rnd_ack;
   logic [7:0] out_s0;
   logic [7:0] out_s1;
   logic       out_valid;
   logic       sbox_valid;
   logic       sbox_last;

   modport master (
      output in_valid, in_s0, in_s1, rnd, rnd_valid,
      input  in_ready, rnd_ack, out_s0, out_s1, out_valid, sbox_valid, sbox_last
   );

   modport slave (
      input  in_valid, in_s0, in_s1, rnd, rnd_valid,
      output in_ready, rnd_ack, out_s0, out_s1, out_valid, sbox_valid, sbox_last
   );
endinterface

// File: rtl/sbox_share_feeder.sv
// Masked 2-share feeder for the Canright AES S-box: 2-entry FIFO, share refresh, issue register, latency tracker.
// Share refresh with rnd is compiled in only when the REFRESH_EN macro is defined.
module sbox_share_feeder #(
   parameter int LATENCY = 3,
   parameter int NBYTES  = 16
) (
   input logic                clk,
   input logic                rst_n,
   sbox_share_feeder_if.slave bus
);
   localparam int            IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   logic [7:0]         fifo_s0 [2];
   logic [7:0]         fifo_s1 [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         count;
   logic [IW-1:0]      idx;
   logic               last_q;
   logic [LATENCY-1:0] vsr;
   logic [LATENCY-1:0] lsr;
   logic               accept;
   logic               issue;
   logic               rnd_ok;
   logic [7:0]         mask;

`ifdef REFRESH_EN
   assign rnd_ok      = bus.rnd_valid;
   assign mask        = bus.rnd;
   assign bus.rnd_ack = issue;
`else
   assign rnd_ok      = 1'b1;
   assign mask        = 8'h00;
   assign bus.rnd_ack = 1'b0;
`endif

   assign bus.in_ready = (count != 2'd2);
   assign accept       = bus.in_valid && bus.in_ready;
   assign issue        = (count != 2'd0) && rnd_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_s0[0] <= 8'h00;
         fifo_s0[1] <= 8'h00;
         fifo_s1[0] <= 8'h00;
         fifo_s1[1] <= 8'h00;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
      end else begin
         if (accept) begin
            fifo_s0[wr_ptr] <= bus.in_s0;
            fifo_s1[wr_ptr] <= bus.in_s1;
            wr_ptr          <= ~wr_ptr;
         end
         if (issue) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({accept, issue})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Each share is masked on its own path; the shares never meet, and idle cycles hold
   // the registers so the affine stage sees no spurious share transitions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_s0    <= 8'h00;
         bus.out_s1    <= 8'h00;
         bus.out_valid <= 1'b0;
         last_q        <= 1'b0;
         idx           <= '0;
      end else begin
         bus.out_valid <= issue;
         last_q        <= issue && (idx == LAST_IDX);
         if (issue) begin
            bus.out_s0 <= fifo_s0[rd_ptr] ^ mask;
            bus.out_s1 <= fifo_s1[rd_ptr] ^ mask;
            idx        <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
         end
      end
   end

   // The S-box core cannot stall, so the tracker shifts every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsr <= '0;
         lsr <= '0;
      end else begin
         vsr <= LATENCY'({vsr, bus.out_valid});
         lsr <= LATENCY'({lsr, last_q});
      end
   end

   assign bus.sbox_valid = vsr[LATENCY-1];
   assign bus.sbox_last  = lsr[LATENCY-1] && vsr[LATENCY-1];
endmodule
